// File: rtl/bitcnt_issue.sv
// Issue stage for the bit-count unit: command FIFO -> E register (count logic) -> O register.
// Decodes CLZ/CTZ/CPOP and their word forms; anything else returns as illegal with zero data.
module bitcnt_issue #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_insn,
    input  logic [63:0] in_rs1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [63:0] out_data,
    output logic        out_illegal,
    output logic        busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic        illegal;
        logic [2:0]  func;
        logic [4:0]  rd;
        logic [63:0] rs1;
    } cmd_t;

    cmd_t        dec_cmd;
    cmd_t        fifo_mem [FIFO_DEPTH];
    cmd_t        head_cmd;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        fifo_empty, fifo_full, push, pop;

    logic        e_valid_q, e_valid_d;
    cmd_t        e_cmd_q, e_cmd_d;
    logic        o_valid_q, o_valid_d;
    logic [4:0]  o_rd_q, o_rd_d;
    logic [63:0] o_data_q, o_data_d;
    logic        o_illegal_q, o_illegal_d;
    logic        o_adv;
    logic [6:0]  count;
    logic        unused_insn_bits;

    // rs1 register field is irrelevant here; the operand arrives on in_rs1.
    assign unused_insn_bits = ^in_insn[19:15];

    always_comb begin
        dec_cmd.rd      = in_insn[11:7];
        dec_cmd.rs1     = in_rs1;
        dec_cmd.func    = 3'b000;
        dec_cmd.illegal = 1'b1;
        if (in_insn[31:25] == 7'b0110000 && in_insn[14:12] == 3'b001 &&
            (in_insn[6:0] == 7'b0010011 || in_insn[6:0] == 7'b0011011)) begin
            if (in_insn[24:20] <= 5'd2) begin
                dec_cmd.func    = {in_insn[21:20], in_insn[6:0] == 7'b0011011};
                dec_cmd.illegal = 1'b0;
            end
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready   = resetn && !fifo_full;
    assign push       = in_valid && in_ready;
    assign head_cmd   = fifo_mem[rd_ptr_q[AW-1:0]];

    // E moves forward whenever O can take it; E refills from the FIFO head in the same cycle.
    assign o_adv = !o_valid_q || out_ready;
    assign pop   = !fifo_empty && (!e_valid_q || o_adv);

    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        e_valid_d = e_valid_q;
        e_cmd_d   = e_cmd_q;
        if (pop) begin
            e_valid_d = 1'b1;
            e_cmd_d   = head_cmd;
        end else if (o_adv) begin
            e_valid_d = 1'b0;
        end
    end

    always_comb begin
        logic [6:0] lz64, lz32, tz64, tz32, pc64, pc32;
        lz64 = 7'd64;
        lz32 = 7'd32;
        tz64 = 7'd64;
        tz32 = 7'd32;
        pc64 = 7'd0;
        pc32 = 7'd0;
        for (int i = 0; i < 64; i++) begin
            if (e_cmd_q.rs1[i]) lz64 = 7'(63 - i);
            pc64 = pc64 + {6'd0, e_cmd_q.rs1[i]};
        end
        for (int i = 0; i < 32; i++) begin
            if (e_cmd_q.rs1[i]) lz32 = 7'(31 - i);
            pc32 = pc32 + {6'd0, e_cmd_q.rs1[i]};
        end
        for (int i = 63; i >= 0; i--) begin
            if (e_cmd_q.rs1[i]) tz64 = 7'(i);
        end
        for (int i = 31; i >= 0; i--) begin
            if (e_cmd_q.rs1[i]) tz32 = 7'(i);
        end
        case (e_cmd_q.func)
            3'b000:  count = lz64;
            3'b001:  count = lz32;
            3'b010:  count = tz64;
            3'b011:  count = tz32;
            3'b100:  count = pc64;
            3'b101:  count = pc32;
            default: count = 7'd0;
        endcase
    end

    always_comb begin
        o_valid_d   = o_valid_q;
        o_rd_d      = o_rd_q;
        o_data_d    = o_data_q;
        o_illegal_d = o_illegal_q;
        if (o_adv) begin
            o_valid_d = e_valid_q;
            if (e_valid_q) begin
                o_rd_d      = e_cmd_q.rd;
                o_illegal_d = e_cmd_q.illegal;
                o_data_d    = e_cmd_q.illegal ? 64'd0 : {57'd0, count};
            end
        end
    end

    // Storage has no reset so it can map onto plain RAM; validity lives in the pointers.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= dec_cmd;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            e_valid_q   <= 1'b0;
            e_cmd_q     <= '0;
            o_valid_q   <= 1'b0;
            o_rd_q      <= 5'd0;
            o_data_q    <= 64'd0;
            o_illegal_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            e_valid_q   <= e_valid_d;
            e_cmd_q     <= e_cmd_d;
            o_valid_q   <= o_valid_d;
            o_rd_q      <= o_rd_d;
            o_data_q    <= o_data_d;
            o_illegal_q <= o_illegal_d;
        end
    end

    assign out_valid   = resetn && o_valid_q;
    assign out_rd      = o_rd_q;
    assign out_data    = o_data_q;
    assign out_illegal = o_illegal_q;
    assign busy        = resetn && (!fifo_empty || e_valid_q || o_valid_q);

endmodule

// File: tb/tb_bitcnt_issue.sv
// Directed-vector bench for bitcnt_issue: decode/count results, latency, back-pressure,
// streaming throughput and mid-flight reset.
module tb_bitcnt_issue;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_insn;
    logic [63:0] in_rs1;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [63:0] out_data;
    logic        out_illegal;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bitcnt_issue #(.FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_insn    (in_insn),
        .in_rs1     (in_rs1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_data   (out_data),
        .out_illegal(out_illegal),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated command: accept at edge k, result visible after edge k+2, drained at k+3.
    task automatic run_one(input string tag, input logic [31:0] insn, input logic [63:0] rs1,
                           input logic [4:0] exp_rd, input logic [63:0] exp_data,
                           input logic exp_ill);
        in_valid = 1'b1;
        in_insn  = insn;
        in_rs1   = rs1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk({tag, ".lat1"}, 64'(out_valid), 64'd0);
        step();
        chk({tag, ".lat2"}, 64'(out_valid), 64'd0);
        step();
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".data"}, out_data, exp_data);
        chk({tag, ".rd"}, 64'(out_rd), 64'(exp_rd));
        chk({tag, ".illegal"}, 64'(out_illegal), 64'(exp_ill));
        $display("txn %s insn=%08h rs1=%016h -> data=%0d rd=%0d ill=%0b",
                 tag, insn, rs1, out_data, out_rd, out_illegal);
        step();
        chk({tag, ".drained"}, 64'(out_valid), 64'd0);
        chk({tag, ".idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_insn   = 32'd0;
        in_rs1    = 64'd0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.out_data", out_data, 64'd0);
        chk("rst.out_rd", 64'(out_rd), 64'd0);
        chk("rst.out_illegal", 64'(out_illegal), 64'd0);
        resetn = 1'b1;
        #1;
        chk("rel.in_ready", 64'(in_ready), 64'd1);

        run_one("clz",       32'h60009093, 64'h0000_0000_0001_0000, 5'd1, 64'd47, 1'b0);
        run_one("cpopw",     32'h6020909B, 64'hFFFF_FFFF_0000_00FF, 5'd1, 64'd8,  1'b0);
        run_one("ctz0",      32'h60109093, 64'h0,                   5'd1, 64'd64, 1'b0);
        run_one("ctzw0",     32'h6010909B, 64'hFFFF_FFFF_0000_0000, 5'd1, 64'd32, 1'b0);
        run_one("addi",      32'h00000013, 64'h1234,                5'd0, 64'd0,  1'b1);
        run_one("clzw",      32'h6000909B, 64'hFFFF_FFFF_0000_8000, 5'd1, 64'd16, 1'b0);
        run_one("clzw0",     32'h6000909B, 64'hFFFF_FFFF_0000_0000, 5'd1, 64'd32, 1'b0);
        run_one("cpop",      32'h60209093, 64'hFFFF_FFFF_0000_00FF, 5'd1, 64'd40, 1'b0);
        run_one("ctz",       32'h60109093, 64'h0000_0000_0000_0100, 5'd1, 64'd8,  1'b0);
        run_one("clz_rd0",   32'h60009013, 64'h8000_0000_0000_0000, 5'd0, 64'd0,  1'b0);
        run_one("clz_zero",  32'h60009093, 64'h0,                   5'd1, 64'd64, 1'b0);
        run_one("rs2_3",     32'h60309093, 64'hFF,                  5'd1, 64'd0,  1'b1);
        run_one("ctzw_rd31", 32'h60109F9B, 64'h0000_0000_0000_0004, 5'd31, 64'd2, 1'b0);

        // Back-pressure: four fit (FIFO 2 + E + O), the fifth is refused.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_insn  = 32'h60009013 | ((i + 1) << 7);
            in_rs1   = 64'h1 << (4 * i);
            chk($sformatf("bp.in_ready%0d", i), 64'(in_ready), (i < 4) ? 64'd1 : 64'd0);
            step();
        end
        in_valid = 1'b0;
        chk("bp.hold_rd", 64'(out_rd), 64'd1);
        step();
        chk("bp.hold_rd2", 64'(out_rd), 64'd1);
        chk("bp.hold_data", out_data, 64'd63);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp.valid%0d", i), 64'(out_valid), 64'd1);
            chk($sformatf("bp.rd%0d", i), 64'(out_rd), 64'(i + 1));
            chk($sformatf("bp.data%0d", i), out_data, 64'(63 - 4 * i));
            chk($sformatf("bp.busy%0d", i), 64'(busy), 64'd1);
            $display("txn bp%0d rd=%0d data=%0d", i, out_rd, out_data);
            step();
        end
        chk("bp.empty", 64'(out_valid), 64'd0);
        chk("bp.busy_fall", 64'(busy), 64'd0);

        // Streaming with out_ready high: one result per cycle, in order.
        for (int j = 0; j < 6; j++) begin
            if (j < 4) begin
                in_valid = 1'b1;
                in_insn  = 32'h60209013 | ((j + 10) << 7);
                in_rs1   = (64'h1 << (j + 1)) - 64'h1;
                chk($sformatf("st.in_ready%0d", j), 64'(in_ready), 64'd1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (j >= 2) begin
                chk($sformatf("st.valid%0d", j - 2), 64'(out_valid), 64'd1);
                chk($sformatf("st.rd%0d", j - 2), 64'(out_rd), 64'(j + 8));
                chk($sformatf("st.data%0d", j - 2), out_data, 64'(j - 1));
                $display("txn st%0d rd=%0d data=%0d", j - 2, out_rd, out_data);
            end else begin
                chk($sformatf("st.lat%0d", j), 64'(out_valid), 64'd0);
            end
        end
        in_valid = 1'b0;
        step();
        chk("st.drained", 64'(out_valid), 64'd0);

        // Reset with three commands in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_insn  = 32'h60009093;
            in_rs1   = 64'h1 << i;
            step();
        end
        in_valid = 1'b0;
        chk("mr.pre_busy", 64'(busy), 64'd1);
        resetn = 1'b0;
        #1;
        chk("mr.in_ready_low", 64'(in_ready), 64'd0);
        chk("mr.valid_low", 64'(out_valid), 64'd0);
        step();
        chk("mr.valid", 64'(out_valid), 64'd0);
        chk("mr.busy", 64'(busy), 64'd0);
        resetn    = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mr.in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("mr.stale%0d", i), 64'(out_valid), 64'd0);
            chk($sformatf("mr.busy%0d", i), 64'(busy), 64'd0);
        end

        run_one("post_rst", 32'h60009093, 64'h0000_0000_0001_0000, 5'd1, 64'd47, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitcnt_issue.md
BITCNT_ISSUE -- requirements
Module: bitcnt_issue

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, input command FIFO entries (power of two, >= 2).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  command present.
REQ-005 SHALL have port in_ready  output  1  command accepted when in_valid && in_ready at a rising edge.
REQ-006 SHALL have port in_insn  input  32  RISC-V instruction word.
REQ-007 SHALL have port in_rs1  input  64  source operand.
REQ-008 SHALL have port out_valid  output  1  result present.
REQ-009 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready at a rising edge.
REQ-010 SHALL have port out_rd  output  5  destination register, in_insn[11:7] of the command.
REQ-011 SHALL have port out_data  output  64  result, zero-extended count 0..64.
REQ-012 SHALL have port out_illegal  output  1  command did not decode.
REQ-013 SHALL have port busy  output  1  any valid entry in FIFO, E stage or O stage.

Function
REQ-014 SHALL decode: funct7=0110000, funct3=001, opcode=0010011, rs2 00000/00001/00010 -> CLZ_64/CTZ_64/CNT_64 (din_func 000/010/100).
REQ-015 SHALL decode: same funct7/funct3, opcode=0011011, rs2 00000/00001/00010 -> CLZ_32/CTZ_32/CNT_32 (din_func 001/011/101).
REQ-016 SHALL treat every other in_insn as illegal: accepted normally, out_illegal=1, out_data=0.
REQ-017 SHALL instantiate the bitcnt unit combinationally on E-stage registered operand and function; no combinational path from in_* to out_*.
REQ-018 SHALL be a 3-part pipeline: FIFO (FIFO_DEPTH) -> E register -> O register driving out_*.
REQ-019 SHALL drive in_ready = FIFO not full; no same-cycle bypass when full, even if a pop occurs that cycle.
REQ-020 SHALL load E from FIFO head when FIFO non-empty and (E empty or E advancing); E advances when O empty or out_ready=1.
REQ-021 SHALL give latency: command accepted at edge k, FIFO/E/O empty, out_valid=1 after edge k+2.
REQ-022 SHALL sustain throughput one command per cycle with out_ready held 1.
REQ-023 SHALL return results strictly in acceptance order; no drop, no duplication.
REQ-024 SHALL hold out_rd, out_data, out_illegal stable while out_valid=1 && out_ready=0.
REQ-025 SHALL handle simultaneous push and pop on a non-full FIFO: both take effect, occupancy unchanged.
REQ-026 SHALL wrap FIFO pointers modulo FIFO_DEPTH, with full/empty distinguished by an extra pointer bit.
REQ-027 SHALL ignore in_rs1[63:32] for word ops, per the bitcnt unit; CTZ_32/CLZ_32 of zero low word = 32.
REQ-028 SHALL process rd=0 commands like any other.
REQ-029 SHALL hold total capacity FIFO_DEPTH+2 commands under full back-pressure.

Reset
REQ-030 SHALL, on rising edge with resetn=0: empty FIFO, invalidate E and O, out_data=0, out_rd=0, out_illegal=0.
REQ-031 SHALL drive in_ready=0, out_valid=0, busy=0 while resetn=0.
REQ-032 SHALL discard all in-flight commands on reset mid-operation, with no result after release.
REQ-033 SHALL restore in_ready=1 in the first cycle after resetn returns to 1.

Verification
REQ-034 SHALL cover: insn 0x60009093 (clz x1), rs1=0x0000_0000_0001_0000 -> out_data=47, out_rd=1, out_illegal=0, 2 edges after accept.
REQ-035 SHALL cover: insn 0x6020909B (cpopw), rs1=0xFFFF_FFFF_0000_00FF -> out_data=8.
REQ-036 SHALL cover: insn 0x60109093 (ctz), rs1=0 -> 64; ctzw (0x6010909B), rs1=0xFFFF_FFFF_0000_0000 -> 32.
REQ-037 SHALL cover: out_ready=0, FIFO_DEPTH=2, push 5 -> 4 accepted, in_ready=0 on 5th; then out_ready=1 -> 4 results in order, one per cycle; busy falls after last.
REQ-038 SHALL cover: insn 0x00000013 (addi) -> out_illegal=1, out_data=0, out_rd=0.
REQ-039 SHALL cover: 3 commands in flight, resetn=0 one cycle -> out_valid=0, busy=0, no stale result after release.
